// File: rtl/vissched.sv
// vissched: replays each accepted IQ sample for TRATE slots and frames it for the correlator chain.
// Define VISSCHED_STATS_EN to add the frames_o / stalls_o statistics counters.
module vissched #(
  parameter int RADIOS = 32,
  parameter int TRATE  = 30,
  parameter int LOOP0  = 3,
  parameter int LOOP1  = 5
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     enable_i,
  input  logic                     src_valid_i,
  output logic                     src_ready_o,
  input  logic [RADIOS-1:0]        src_dati_i,
  input  logic [RADIOS-1:0]        src_datq_i,
  output logic                     sig_valid_o,
  output logic                     sig_first_o,
  output logic                     sig_next_o,
  output logic                     sig_emit_o,
  output logic                     sig_last_o,
  output logic [$clog2(TRATE)-1:0] sig_addr_o,
  output logic [RADIOS-1:0]        sig_dati_o,
  output logic [RADIOS-1:0]        sig_datq_o,
`ifdef VISSCHED_STATS_EN
  output logic                     busy_o,
  output logic [15:0]              frames_o,
  output logic [15:0]              stalls_o
`else
  output logic                     busy_o
`endif
);
  localparam int AW = $clog2(TRATE);
  localparam int SW = (LOOP0 > 1) ? $clog2(LOOP0) : 1;
  localparam int BW = (LOOP1 > 1) ? $clog2(LOOP1) : 1;
  localparam logic [AW-1:0] TMAX = AW'(TRATE - 1);
  localparam logic [SW-1:0] SMAX = SW'(LOOP0 - 1);
  localparam logic [BW-1:0] BMAX = BW'(LOOP1 - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     tcnt_q, tcnt_d;
  logic [SW-1:0]     scnt_q, scnt_d, scnt_adv;
  logic [BW-1:0]     bcnt_q, bcnt_d, bcnt_adv;
  logic              hold_v_q, hold_v_d;
  logic              first_q, first_d, emit_q, emit_d, last_q, last_d;
  logic [RADIOS-1:0] dati_q, datq_q;
  logic              active, slot_end, last_slot, boundary, frame_done, accept;

  // Handshake: in DRAIN the frame is done once its last sample is held, or when sitting on a boundary.
  always_comb begin
    active      = (state_q != IDLE);
    slot_end    = hold_v_q && (tcnt_q == TMAX);
    last_slot   = slot_end && last_q;
    boundary    = !hold_v_q && (scnt_q == '0) && (bcnt_q == '0);
    frame_done  = (state_q == DRAIN) && ((hold_v_q && last_q) || boundary);
    src_ready_o = active && (!hold_v_q || (tcnt_q == TMAX)) && !frame_done;
    accept      = src_valid_i && src_ready_o;
  end

  // scnt_adv/bcnt_adv are the counters after the current sample retires; a sample
  // accepted in the same cycle takes its qualifiers from these.
  always_comb begin
    scnt_adv = scnt_q;
    bcnt_adv = bcnt_q;
    if (slot_end) begin
      if (scnt_q == SMAX) begin
        scnt_adv = '0;
        bcnt_adv = (bcnt_q == BMAX) ? '0 : bcnt_q + 1'b1;
      end else begin
        scnt_adv = scnt_q + 1'b1;
      end
    end
    tcnt_d   = tcnt_q;
    scnt_d   = scnt_adv;
    bcnt_d   = bcnt_adv;
    hold_v_d = hold_v_q;
    first_d  = first_q;
    emit_d   = emit_q;
    last_d   = last_q;
    if (state_q == IDLE) begin
      tcnt_d   = '0;
      scnt_d   = '0;
      bcnt_d   = '0;
      hold_v_d = 1'b0;
    end else if (accept) begin
      tcnt_d   = '0;
      hold_v_d = 1'b1;
      first_d  = (scnt_adv == '0);
      emit_d   = (scnt_adv == SMAX);
      last_d   = (scnt_adv == SMAX) && (bcnt_adv == BMAX);
    end else if (slot_end) begin
      tcnt_d   = '0;
      hold_v_d = 1'b0;
    end else if (hold_v_q) begin
      tcnt_d   = tcnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable_i) state_d = RUN;
      RUN:     if (!enable_i) state_d = DRAIN;
      DRAIN:   if (enable_i) state_d = RUN;
               else if (last_slot || boundary) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      tcnt_q   <= '0;
      scnt_q   <= '0;
      bcnt_q   <= '0;
      hold_v_q <= 1'b0;
      first_q  <= 1'b0;
      emit_q   <= 1'b0;
      last_q   <= 1'b0;
      dati_q   <= '0;
      datq_q   <= '0;
    end else begin
      state_q  <= state_d;
      tcnt_q   <= tcnt_d;
      scnt_q   <= scnt_d;
      bcnt_q   <= bcnt_d;
      hold_v_q <= hold_v_d;
      first_q  <= first_d;
      emit_q   <= emit_d;
      last_q   <= last_d;
      if (accept) begin
        dati_q <= src_dati_i;
        datq_q <= src_datq_i;
      end
    end
  end

  // Qualifiers and address read as zero between samples; data keeps its last value.
  always_comb begin
    busy_o      = active;
    sig_valid_o = hold_v_q;
    sig_addr_o  = hold_v_q ? tcnt_q : '0;
    sig_next_o  = slot_end;
    sig_first_o = hold_v_q && first_q;
    sig_emit_o  = hold_v_q && emit_q;
    sig_last_o  = hold_v_q && last_q;
    sig_dati_o  = dati_q;
    sig_datq_o  = datq_q;
  end

`ifdef VISSCHED_STATS_EN
  logic [15:0] frames_q, stalls_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frames_q <= '0;
      stalls_q <= '0;
    end else begin
      if (last_slot) frames_q <= frames_q + 16'd1;
      if (active && !hold_v_q && !((scnt_q == '0) && (bcnt_q == '0)) && (stalls_q != 16'hFFFF))
        stalls_q <= stalls_q + 16'd1;
    end
  end

  assign frames_o = frames_q;
  assign stalls_o = stalls_q;
`endif

endmodule
